// File: rtl/fp_normalize.sv
// fp_normalize: back end of the FPU add/sub path.
//
// Takes the aligned magnitude sum (larger operand first), normalises it one
// bit per cycle, rounds to nearest-even and packs an IEEE single-precision
// word. Non-pipelined: one operation in flight at a time.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready only in IDLE, out of reset)
//   in_sign, in_exp       sign and biased exponent of the larger operand
//   in_sum                {carry, hidden, fraction} raw magnitude
//   in_grs                guard, round, sticky (MSB first)
//   out_valid / out_ready downstream handshake; result held until taken
//   out_fp                packed result
//   out_ovf, out_unf      overflow-to-infinity, underflow-flushed-to-zero

package fp_types;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } IEEE_fp;
endpackage

module fp_normalize #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [MANT_W+1:0]    in_sum,
  input  logic [2:0]           in_grs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output fp_types::IEEE_fp     out_fp,
  output logic                 out_ovf,
  output logic                 out_unf
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHIFT,
    ROUND,
    DONE
  } state_e;

  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_INF = (EXP_W+2)'((1 << EXP_W) - 1);

  state_e                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W+1:0]  exp_q, exp_d;
  logic [MANT_W+1:0]        mant_q, mant_d;
  logic [2:0]               grs_q, grs_d;
  // zero_q: result is forced to a signed zero in ROUND (true zero or flush).
  // unf_q:  that forced zero came from an underflow flush.
  logic                     zero_q, zero_d;
  logic                     unf_q, unf_d;
  fp_types::IEEE_fp         out_fp_q, out_fp_d;
  logic                     out_ovf_q, out_ovf_d;
  logic                     out_unf_q, out_unf_d;

  logic                     do_lshift;
  logic                     round_up;
  logic [MANT_W:0]          frac_rnd;
  logic signed [EXP_W+1:0]  exp_rnd;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign out_fp    = out_fp_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    grs_d     = grs_q;
    zero_d    = zero_q;
    unf_d     = unf_q;
    out_fp_d  = out_fp_q;
    out_ovf_d = out_ovf_q;
    out_unf_d = out_unf_q;
    do_lshift = 1'b0;

    // Round to nearest-even on the 23-bit fraction; a carry out of the
    // fraction leaves it all zeros and bumps the exponent.
    round_up = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
    frac_rnd = {1'b0, mant_q[MANT_W-1:0]} + {{MANT_W{1'b0}}, round_up};
    exp_rnd  = exp_q + {{(EXP_W+1){1'b0}}, frac_rnd[MANT_W]};

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d    = in_sign;
          exp_d     = {2'b00, in_exp};
          mant_d    = in_sum;
          grs_d     = in_grs;
          zero_d    = 1'b0;
          unf_d     = 1'b0;
          out_ovf_d = 1'b0;
          out_unf_d = 1'b0;
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (mant_q == '0 && grs_q == '0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (mant_q[MANT_W+1]) begin
          mant_d  = {1'b0, mant_q[MANT_W+1:1]};
          grs_d   = {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (mant_q[MANT_W]) begin
          state_d = ROUND;
        end else begin
          do_lshift = 1'b1;
        end
      end

      // The hidden bit is tested one cycle after each shift, so every left
      // shift costs a full cycle before ROUND is entered.
      SHIFT: begin
        if (mant_q[MANT_W]) begin
          state_d = ROUND;
        end else begin
          do_lshift = 1'b1;
        end
      end

      ROUND: begin
        out_fp_d.sign = sign_q;
        if (zero_q) begin
          out_fp_d.exp  = '0;
          out_fp_d.mant = '0;
          out_unf_d     = unf_q;
        end else if (exp_rnd >= EXP_INF) begin
          out_fp_d.exp  = '1;
          out_fp_d.mant = '0;
          out_ovf_d     = 1'b1;
        end else begin
          out_fp_d.exp  = exp_rnd[EXP_W-1:0];
          out_fp_d.mant = frac_rnd[MANT_W-1:0];
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared left-shift step. At the minimum exponent the value cannot be
    // normalised without a denormal, so it is flushed to a signed zero; the
    // flush still passes through ROUND so its latency matches a shift cycle.
    if (do_lshift) begin
      if (exp_q == EXP_ONE) begin
        zero_d  = 1'b1;
        unf_d   = 1'b1;
        state_d = ROUND;
      end else begin
        mant_d  = {mant_q[MANT_W:0], grs_q[2]};
        grs_d   = {grs_q[1], 1'b0, grs_q[0]};
        exp_d   = exp_q - EXP_ONE;
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      grs_q     <= '0;
      zero_q    <= 1'b0;
      unf_q     <= 1'b0;
      out_fp_q  <= '0;
      out_ovf_q <= 1'b0;
      out_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      grs_q     <= grs_d;
      zero_q    <= zero_d;
      unf_q     <= unf_d;
      out_fp_q  <= out_fp_d;
      out_ovf_q <= out_ovf_d;
      out_unf_q <= out_unf_d;
    end
  end

endmodule
